// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: configurable word width and SCLK divider, all four
// CPOL/CPHA modes, MSB/LSB-first order, internal loopback and synchronous abort.
//
// state   | meaning
// S_IDLE  | cs_n high, sclk follows cpol input, waiting for start
// S_LEAD  | cs_n low, one half-period before the first SCLK edge
// S_XFER  | 2*DATA_W half-periods, SCLK toggles at the end of each
// S_TRAIL | sclk back at cpol, cs_n still low for one half-period
// S_DONE  | cs_n high, done pulse, rx_data updated
module spi_master_cfg #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              loopback,
  input  logic [DIV_W-1:0]  div,
  input  logic              abort,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_hcnt, r_div;
  logic [BW-1:0]     r_bitcnt;
  logic              r_phase, r_cpol, r_cpha, r_lsb, r_loop, r_sclk, r_mosi;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              w_tc, w_last, w_rx_in, w_tx_head, w_in_head;
  logic [DATA_W-1:0] w_rx_shift, w_tx_shift, w_in_shift;

  assign w_tc       = (r_hcnt == '0);
  assign w_last     = r_phase && (r_bitcnt == '0);
  assign w_rx_in    = r_loop ? r_mosi : miso;
  assign w_rx_shift = r_lsb ? {w_rx_in, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], w_rx_in};
  assign w_tx_head  = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
  assign w_tx_shift = r_lsb ? (r_tx >> 1) : (r_tx << 1);
  assign w_in_head  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
  assign w_in_shift = lsb_first ? (tx_data >> 1) : (tx_data << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cs_n        = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cs_n = 1'b1;
        busy = 1'b0;
        if (start) w_state_nxt = S_LEAD;
      end
      S_LEAD:  if (abort) w_state_nxt = S_IDLE; else if (w_tc) w_state_nxt = S_XFER;
      S_XFER:  if (abort) w_state_nxt = S_IDLE; else if (w_tc && w_last) w_state_nxt = S_TRAIL;
      S_TRAIL: if (abort) w_state_nxt = S_IDLE; else if (w_tc) w_state_nxt = S_DONE;
      S_DONE: begin
        cs_n        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt    <= '0;
      r_div     <= '0;
      r_bitcnt  <= '0;
      r_phase   <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_loop    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk <= cpol;
          if (start) begin
            r_cpol   <= cpol;
            r_cpha   <= cpha;
            r_lsb    <= lsb_first;
            r_loop   <= loopback;
            r_div    <= div;
            r_hcnt   <= div;
            r_bitcnt <= BW'(DATA_W - 1);
            r_phase  <= 1'b0;
            r_rx     <= '0;
            // CPHA=0 presents the first bit before any SCLK edge
            if (!cpha) begin
              r_mosi <= w_in_head;
              r_tx   <= w_in_shift;
            end else begin
              r_tx   <= tx_data;
            end
          end
        end
        S_LEAD, S_TRAIL: begin
          if (abort) begin
            r_sclk <= r_cpol;
          end else if (w_tc) begin
            r_hcnt <= r_div;
            if (r_state == S_TRAIL) r_rx_data <= r_rx;
          end else begin
            r_hcnt <= r_hcnt - 1'b1;
          end
        end
        S_XFER: begin
          if (abort) begin
            r_sclk <= r_cpol;
          end else if (w_tc) begin
            r_hcnt  <= r_div;
            r_sclk  <= ~r_sclk;
            r_phase <= ~r_phase;
            if (!r_phase) begin
              if (r_cpha) begin
                r_mosi <= w_tx_head;
                r_tx   <= w_tx_shift;
              end else begin
                r_rx   <= w_rx_shift;
              end
            end else begin
              if (r_cpha) r_rx <= w_rx_shift;
              if (r_bitcnt != '0) begin
                r_bitcnt <= r_bitcnt - 1'b1;
                if (!r_cpha) begin
                  r_mosi <= w_tx_head;
                  r_tx   <= w_tx_shift;
                end
              end
            end
          end else begin
            r_hcnt <= r_hcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed self-checking bench for spi_master_cfg (DATA_W=16, DIV_W=8) with a
// behavioural SPI slave that returns a fixed word and records what it receives.
module tb_spi_master_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        lsb_first = 1'b0;
  logic        loopback = 1'b0;
  logic [7:0]  div = '0;
  logic        abort = 1'b0;
  logic        miso = 1'b0;
  logic        sclk, mosi, cs_n, busy, done;
  logic [15:0] rx_data;

  int n_tests = 0;
  int n_fail  = 0;
  int d0 = 0;
  int r0 = 0;

  spi_master_cfg #(.DATA_W(16), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .loopback(loopback), .div(div),
    .abort(abort), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .busy(busy), .done(done), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // Bus monitor: cycle-accurate cs_n fall / done timing and SCLK rising edges
  int   cyc = 0, fall_cyc = 0, done_cyc = 0, done_cnt = 0, rise_cnt = 0;
  logic prev_cs = 1'b1, first_mosi = 1'b0, sclk_at_fall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !cs_n) begin
      fall_cyc     = cyc;
      first_mosi   = mosi;
      sclk_at_fall = sclk;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    prev_cs = cs_n;
  end

  always @(posedge sclk) if (!cs_n) rise_cnt++;

  // MSB-first slave; leading edge = transition away from cpol
  logic [15:0] s_word = 16'h3C96, s_tx = '0, s_rx = '0;
  logic        s_prev_cs = 1'b1, s_prev_sclk = 1'b0;

  always @(cs_n or sclk) begin
    if (!cs_n && s_prev_cs) begin
      s_tx = s_word;
      s_rx = '0;
      if (!cpha) begin
        miso = s_tx[15];
        s_tx = s_tx << 1;
      end
    end else if (!cs_n && (sclk !== s_prev_sclk)) begin
      if ((sclk != cpol) != cpha) begin
        s_rx = {s_rx[14:0], mosi};
      end else begin
        miso = s_tx[15];
        s_tx = s_tx << 1;
      end
    end
    s_prev_cs   = cs_n;
    s_prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] tx, input logic pol, input logic pha,
                        input logic lsb, input logic lb, input logic [7:0] dv,
                        input logic ab);
    cpol = pol; cpha = pha; lsb_first = lsb; loopback = lb; div = dv;
    @(negedge clk);
    d0 = done_cnt;
    r0 = rise_cnt;
    tx_data = tx; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, MSB first, loopback, H=2
    launch(16'hA55A, 0, 0, 0, 1, 8'd1, 0);
    chk("t1_busy", busy, 1);
    wait_done("t1");
    chk("t1_rx", rx_data, 16'hA55A);
    chk("t1_lat", done_cyc - fall_cyc, 68);
    chk("t1_rises", rise_cnt - r0, 16);
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_cs_end", cs_n, 1);

    // modes 1..3 against the slave, H=4
    for (int m = 1; m < 4; m++) begin
      s_word = 16'h3C96;
      launch(16'hA55A, m[1], m[0], 0, 0, 8'd3, 0);
      wait_done("mode");
      chk("mode_rx", rx_data, 16'h3C96);
      chk("mode_slave_rx", s_rx, 16'hA55A);
      chk("mode_sclk_pre", sclk_at_fall, m[1]);
      chk("mode_lat", done_cyc - fall_cyc, 136);
      chk("mode_rises", rise_cnt - r0, 16);
      @(negedge clk);
      chk("mode_sclk_post", sclk, m[1]);
    end

    // LSB first: only the first bit on the wire is 1
    launch(16'h0001, 0, 0, 1, 1, 8'd1, 0);
    wait_done("lsb");
    chk("lsb_first_bit", first_mosi, 1);
    chk("lsb_wire", s_rx, 16'h8000);
    chk("lsb_rx", rx_data, 16'h0001);

    // start during a transfer is ignored
    launch(16'hA55A, 0, 0, 0, 1, 8'd1, 0);
    repeat (20) @(negedge clk);
    tx_data = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid");
    chk("mid_rx", rx_data, 16'hA55A);
    chk("mid_lat", done_cyc - fall_cyc, 68);
    repeat (100) @(negedge clk);
    chk("mid_single_done", done_cnt - d0, 1);

    // abort around bit 7
    launch(16'h1234, 0, 0, 0, 1, 8'd1, 0);
    for (int n = 0; n < 1000 && (rise_cnt - r0) < 9; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_cs_n", cs_n, 1);
    chk("abt_busy", busy, 0);
    chk("abt_sclk", sclk, 0);
    repeat (100) @(negedge clk);
    chk("abt_no_done", done_cnt - d0, 0);
    chk("abt_rx_kept", rx_data, 16'hA55A);

    // start and abort together in IDLE: start wins
    launch(16'h0F0F, 0, 0, 0, 1, 8'd1, 1);
    wait_done("abt_next");
    chk("abt_next_rx", rx_data, 16'h0F0F);

    // async reset mid-transfer, then a div=0 transfer
    launch(16'hBEEF, 1, 1, 0, 1, 8'd1, 0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_sclk", sclk, 0);
    chk("mrst_mosi", mosi, 0);
    chk("mrst_cs_n", cs_n, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rx", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'h1357, 0, 0, 0, 1, 8'd0, 0);
    wait_done("div0");
    chk("div0_lat", done_cyc - fall_cyc, 34);
    chk("div0_rx", rx_data, 16'h1357);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
